imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_to_word.sv | 29 ++
 rtl/imem_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Frame state encodings are reused by the bench.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler: byte k lands in bits [8k+7:8k].
// word_valid fires in the cycle the fourth byte is taken.
module imem_loader_byte_to_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        take,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] part;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx  <= 2'd0;
            part <= 24'd0;
        end else if (take) begin
            idx <= idx + 2'd1;
            if (idx != 2'd3)
                part[{idx, 3'b000} +: 8] <= in_byte;
        end
    end

    assign word_valid = take && (idx == 2'd3);
    assign word       = {in_byte, part};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in
// reset until the image is written and its XOR checksum verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    state_t             state;
    logic [7:0]         cnt_lo;
    logic [7:0]         acc;
    logic [CNT_W-1:0]   remaining;
    logic [31:0]        next_addr;
    logic               accept;
    logic               take;
    logic               word_valid;
    logic [31:0]        word;
    logic [CNT_W-1:0]   n;

    // Gate with reset so the source sees no ready while reset is held.
    assign byte_ready = reset && (state != DONE) && (state != ERR);
    assign accept     = byte_valid && byte_ready;
    assign take       = accept && (state == DATA);
    assign n          = {byte_data, cnt_lo};

    imem_loader_byte_to_word u_b2w (
        .clk        (clk),
        .reset      (reset),
        .take       (take),
        .in_byte    (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HDR0;
            cnt_lo     <= 8'd0;
            acc        <= 8'd0;
            remaining  <= '0;
            next_addr  <= BASE_ADDR;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= word_valid;
            if (word_valid) begin
                imem_addr  <= next_addr;
                imem_wdata <= word;
                next_addr  <= next_addr + 32'd4;
            end
            if (accept) begin
                unique case (state)
                    HDR0: begin
                        cnt_lo <= byte_data;
                        acc    <= acc ^ byte_data;
                        state  <= HDR1;
                    end
                    HDR1: begin
                        acc       <= acc ^ byte_data;
                        remaining <= n;
                        if ({17'd0, n} > DEPTH) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (n == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        acc <= acc ^ byte_data;
                        if (word_valid) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == 16'd1)
                                state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (byte_data == acc) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
